// File: rtl/sram_access_arbiter_if.sv
// Signal bundle between the SRAM arbiter, its two requesters and the SRAM pins.
// slave  : arbiter view (Avalon-MM slave, hardware-port responder, SRAM pin driver).
// master : environment view (Nios II interconnect, board logic, SRAM device).
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  // Avalon-MM slave port
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  // hardware port (board logic)
  logic              hw_req;
  logic              hw_we;
  logic [ADDR_W-1:0] hw_addr;
  logic [DATA_W-1:0] hw_wdata;
  logic [DATA_W-1:0] hw_rdata;
  logic              hw_ack;
  // SRAM pins
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_out;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_in;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest,
    input  hw_req, hw_we, hw_addr, hw_wdata,
    output hw_rdata, hw_ack,
    output sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_dq_in,
    output sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest,
    output hw_req, hw_we, hw_addr, hw_wdata,
    input  hw_rdata, hw_ack,
    input  sram_addr, sram_dq_out, sram_dq_oe,
    output sram_dq_in,
    input  sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Purpose : shares one asynchronous SRAM between an Avalon-MM slave and a board hardware port,
//           turning single-word requests into timed SETUP/ACCESS/DONE SRAM cycles (round-robin on ties).
// Latency : 1 (IDLE) + 1 (SETUP) + WAIT_CYCLES (ACCESS) + 1 (DONE) cycles; minimum period WAIT_CYCLES+3.
// Backpres: Avalon held off with avs_waitrequest until its DONE cycle; hw_req is held until hw_ack.
// Ports   : clk, reset_n (async, active low); bus (slave modport) carries avs_*, hw_* and sram_* signals.
// WAIT_CYCLES must lie in 1..15 (4-bit down-counter).
module sram_access_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sram_access_arbiter_if.slave bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  typedef enum logic {GNT_AVS, GNT_HW} grant_t;

  state_t            state;
  grant_t            grant;
  grant_t            last_grant;
  logic              is_wr;
  logic [CNT_W-1:0]  cnt;
  logic              avs_done;

  logic              avs_pend;
  logic              hw_pend;
  logic              pick_avs;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign avs_pend = bus.avs_read | bus.avs_write;
  assign hw_pend  = bus.hw_req;

  // AVS wins when it is alone, or on a tie when HW had the previous grant.
  assign pick_avs  = avs_pend & (~hw_pend | (last_grant == GNT_HW));
  // Read and write asserted together on Avalon is a write.
  assign sel_wr    = pick_avs ? bus.avs_write     : bus.hw_we;
  assign sel_addr  = pick_avs ? bus.avs_address   : bus.hw_addr;
  assign sel_wdata = pick_avs ? bus.avs_writedata : bus.hw_wdata;

  // avs_done is high exactly during DONE of an AVS grant, so this matches
  // (avs_read|avs_write) & ~(state==DONE & grant==AVS) without decoding state here.
  assign bus.avs_waitrequest = avs_pend & ~avs_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant            <= GNT_AVS;
      last_grant       <= GNT_HW;
      is_wr            <= 1'b0;
      cnt              <= '0;
      avs_done         <= 1'b0;
      bus.hw_ack       <= 1'b0;
      bus.avs_readdata <= '0;
      bus.hw_rdata     <= '0;
      bus.sram_addr    <= '0;
      bus.sram_dq_out  <= '0;
      bus.sram_dq_oe   <= 1'b0;
      bus.sram_ce_n    <= 1'b1;
      bus.sram_oe_n    <= 1'b1;
      bus.sram_we_n    <= 1'b1;
    end else begin
      // completion indications are single-cycle
      avs_done   <= 1'b0;
      bus.hw_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (avs_pend | hw_pend) begin
            grant      <= pick_avs ? GNT_AVS : GNT_HW;
            last_grant <= pick_avs ? GNT_AVS : GNT_HW;
            is_wr      <= sel_wr;
            // The pin registers double as the request latch; they present
            // SETUP values from the first cycle after the grant.
            bus.sram_addr <= sel_addr;
            if (sel_wr) begin
              bus.sram_dq_out <= sel_wdata;
            end
            bus.sram_ce_n  <= 1'b0;
            bus.sram_dq_oe <= sel_wr;
            bus.sram_oe_n  <= sel_wr;
            state          <= SETUP;
          end
        end

        SETUP: begin
          cnt <= CNT_W'(WAIT_CYCLES - 1);
          if (is_wr) begin
            bus.sram_we_n <= 1'b0;
          end
          state <= ACCESS;
        end

        ACCESS: begin
          if (cnt == '0) begin
            // Leaving ACCESS: end the strobe and capture read data on this edge.
            bus.sram_we_n <= 1'b1;
            bus.sram_oe_n <= 1'b1;
            if (!is_wr) begin
              if (grant == GNT_AVS) begin
                bus.avs_readdata <= bus.sram_dq_in;
              end else begin
                bus.hw_rdata <= bus.sram_dq_in;
              end
            end
            if (grant == GNT_AVS) begin
              avs_done <= 1'b1;
            end else begin
              bus.hw_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          // Address and write data were held through DONE for SRAM hold time.
          bus.sram_ce_n  <= 1'b1;
          bus.sram_dq_oe <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int WC    = 2;
  localparam int WC1   = 1;
  localparam int BOUND = 100;

  typedef enum {REQ_AVS, REQ_HW} req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  // Asynchronous SRAM devices: combinational read while selected, write while we_n low.
  logic [DW-1:0] mem0 [0:1023] = '{default: '0};
  logic [DW-1:0] mem1 [0:1023] = '{default: '0};
  assign bus.sram_dq_in  = (!bus.sram_ce_n  && !bus.sram_oe_n)  ? mem0[bus.sram_addr]  : 16'hBAD0;
  assign bus1.sram_dq_in = (!bus1.sram_ce_n && !bus1.sram_oe_n) ? mem1[bus1.sram_addr] : 16'hBAD1;
  always @(posedge clk) if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) mem0[bus.sram_addr] <= bus.sram_dq_out;
  always @(posedge clk) if (!bus1.sram_ce_n && !bus1.sram_we_n && bus1.sram_dq_oe) mem1[bus1.sram_addr] <= bus1.sram_dq_out;

  // Reference model state: memory contents and last granted requester.
  logic [DW-1:0] ref_mem [0:1023] = '{default: '0};
  req_t          lg_model = REQ_HW;

  // Per-access pin bookkeeping (one record per ce_n low window) and pulse counters.
  int            ce_lo = 0, we_lo = 0, oe_lo = 0;
  logic [AW-1:0] addr_seen = '0;
  bit            addr_ok = 1'b1;
  int            acc_ce_lo = 0, acc_we_lo = 0, acc_oe_lo = 0;
  logic [AW-1:0] acc_addr = '0;
  bit            acc_addr_ok = 1'b0;
  int            ack_count = 0;

  always @(negedge clk) begin
    if (bus.hw_ack) ack_count++;
    if (!bus.sram_ce_n) begin
      if (ce_lo == 0) begin
        addr_seen = bus.sram_addr;
        addr_ok   = 1'b1;
      end else if (bus.sram_addr !== addr_seen) begin
        addr_ok = 1'b0;
      end
      ce_lo++;
      if (!bus.sram_we_n) we_lo++;
      if (!bus.sram_oe_n) oe_lo++;
    end else if (ce_lo != 0) begin
      acc_ce_lo = ce_lo; acc_we_lo = we_lo; acc_oe_lo = oe_lo;
      acc_addr = addr_seen; acc_addr_ok = addr_ok;
      ce_lo = 0; we_lo = 0; oe_lo = 0;
    end
  end

  // Inputs change 1 time unit after the falling edge, outputs are read there too.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // lat counts falling edges from the request until completion is seen; with the
  // arbiter idle that is SETUP + WAIT_CYCLES + DONE = WAIT_CYCLES+2.
  task automatic avs_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int lat, output int stamp);
    tick();
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = we; bus.avs_read = ~we;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.avs_waitrequest && lat < BOUND);
    rd = bus.avs_readdata;
    stamp = cyc;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0;
  endtask

  task automatic hw_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output int lat, output int stamp);
    tick();
    bus.hw_addr = a; bus.hw_wdata = d; bus.hw_we = we; bus.hw_req = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.hw_ack && lat < BOUND);
    rd = bus.hw_rdata;
    stamp = cyc;
    bus.hw_req = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== 4'b1110) begin
      failures++; $display("FAIL reset_strobes: got %b expected 1110", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}); end
    checks++; if ({bus.sram_addr, bus.sram_dq_out} !== '0) begin
      failures++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.sram_addr, bus.sram_dq_out); end
    checks++; if ({bus.avs_readdata, bus.hw_rdata, bus.hw_ack} !== '0) begin
      failures++; $display("FAIL reset_rdata_ack: got %h/%h/%b expected 0/0/0", bus.avs_readdata, bus.hw_rdata, bus.hw_ack); end
    reset_n = 1'b1;
    lg_model = REQ_HW;
    repeat (3) tick();
    checks++; if (ack_count !== 0 || bus.sram_ce_n !== 1'b1 || bus.avs_waitrequest !== 1'b0) begin
      failures++; $display("FAIL reset_release_idle: acks %0d ce_n %b waitreq %b expected 0 1 0", ack_count, bus.sram_ce_n, bus.avs_waitrequest); end
  endtask

  task automatic test_avs_write_read();
    logic [DW-1:0] rd; int lat, st;
    avs_xfer(1'b1, 10'h155, 16'hA5C3, rd, lat, st);
    ref_mem[10'h155] = 16'hA5C3;
    lg_model = REQ_AVS;
    checks++; if (lat !== WC + 2) begin
      failures++; $display("FAIL avs_write_latency: got %0d expected %0d", lat, WC + 2); end
    tick();
    checks++; if (bus.avs_waitrequest !== 1'b0) begin
      failures++; $display("FAIL avs_idle_waitreq: got %b expected 0", bus.avs_waitrequest); end
    checks++; if (acc_we_lo !== WC || acc_ce_lo !== WC + 2) begin
      failures++; $display("FAIL avs_write_strobes: we_lo %0d ce_lo %0d expected %0d %0d", acc_we_lo, acc_ce_lo, WC, WC + 2); end
    checks++; if (acc_addr !== 10'h155 || !acc_addr_ok) begin
      failures++; $display("FAIL avs_write_addr: got %h stable %b expected 155 1", acc_addr, acc_addr_ok); end
    avs_xfer(1'b0, 10'h155, 16'h0000, rd, lat, st);
    checks++; if (lat !== WC + 2) begin
      failures++; $display("FAIL avs_read_latency: got %0d expected %0d", lat, WC + 2); end
    checks++; if (rd !== ref_mem[10'h155]) begin
      failures++; $display("FAIL avs_read_data: got %h expected %h", rd, ref_mem[10'h155]); end
    tick();
    checks++; if (acc_oe_lo !== WC + 1 || acc_we_lo !== 0) begin
      failures++; $display("FAIL avs_read_strobes: oe_lo %0d we_lo %0d expected %0d 0", acc_oe_lo, acc_we_lo, WC + 1); end
  endtask

  // Both requesters present from reset and re-request right after each completion.
  task automatic test_round_robin();
    logic [AW-1:0] a_avs [2]; logic [AW-1:0] a_hw [2];
    logic [DW-1:0] rd_a [2];  logic [DW-1:0] rd_h [2];
    int lat_a [2]; int lat_h [2]; int st_a [2]; int st_h [2];
    int ack_base;
    a_avs[0] = 10'h155;
    a_avs[1] = AW'($urandom_range(256, 319));
    a_hw[0]  = AW'($urandom_range(256, 319));
    a_hw[1]  = AW'($urandom_range(256, 319));
    tick(); reset_n = 1'b0; tick(); reset_n = 1'b1;
    lg_model = REQ_HW;
    ack_base = ack_count;
    fork
      begin for (int i = 0; i < 2; i++) avs_xfer(1'b0, a_avs[i], '0, rd_a[i], lat_a[i], st_a[i]); end
      begin for (int i = 0; i < 2; i++) hw_xfer(1'b0, a_hw[i], '0, rd_h[i], lat_h[i], st_h[i]); end
    join
    lg_model = REQ_HW;
    checks++; if (lat_a[0] !== WC + 2) begin
      failures++; $display("FAIL rr_first_avs_latency: got %0d expected %0d", lat_a[0], WC + 2); end
    checks++; if (st_h[0] - st_a[0] !== WC + 3 || st_a[1] - st_h[0] !== WC + 3 || st_h[1] - st_a[1] !== WC + 3) begin
      failures++; $display("FAIL rr_order: gaps %0d %0d %0d expected %0d each", st_h[0] - st_a[0], st_a[1] - st_h[0], st_h[1] - st_a[1], WC + 3); end
    checks++; if (ack_count - ack_base !== 2) begin
      failures++; $display("FAIL rr_hw_ack_count: got %0d expected 2", ack_count - ack_base); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rd_a[i] !== ref_mem[a_avs[i]] || rd_h[i] !== ref_mem[a_hw[i]]) begin
        failures++; $display("FAIL rr_data%0d: got %h/%h expected %h/%h", i, rd_a[i], rd_h[i], ref_mem[a_avs[i]], ref_mem[a_hw[i]]); end
    end
  endtask

  // Board logic drops hw_req for one cycle between commands, so acks land WAIT_CYCLES+4 apart.
  task automatic test_hw_back_to_back();
    logic [DW-1:0] rd; int lat, st1, st2;
    hw_xfer(1'b1, 10'h3FF, 16'h00FF, rd, lat, st1);
    ref_mem[10'h3FF] = 16'h00FF;
    checks++; if (lat !== WC + 2) begin
      failures++; $display("FAIL hw_write_latency: got %0d expected %0d", lat, WC + 2); end
    tick();
    checks++; if (acc_we_lo !== WC || acc_addr !== 10'h3FF || !acc_addr_ok) begin
      failures++; $display("FAIL hw_write_pins: we_lo %0d addr %h stable %b expected %0d 3ff 1", acc_we_lo, acc_addr, acc_addr_ok, WC); end
    hw_xfer(1'b0, 10'h3FF, '0, rd, lat, st2);
    lg_model = REQ_HW;
    checks++; if (st2 - st1 !== WC + 4) begin
      failures++; $display("FAIL hw_ack_spacing: got %0d expected %0d", st2 - st1, WC + 4); end
    checks++; if (rd !== ref_mem[10'h3FF] || bus.sram_addr !== 10'h3FF) begin
      failures++; $display("FAIL hw_read: data %h addr %h expected %h 3ff", rd, bus.sram_addr, ref_mem[10'h3FF]); end
    repeat (2) tick();
    checks++; if (bus.hw_rdata !== 16'h00FF) begin
      failures++; $display("FAIL hw_rdata_hold: got %h expected 00ff", bus.hw_rdata); end
  endtask

  task automatic test_random();
    int mode, la, lh, sa, sh, ela, elh;
    logic wa, wh; logic [AW-1:0] aa, ah; logic [DW-1:0] da, dh, ea, eh, ra, rh;
    bit avs_first;
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 2);   // 0: AVS only, 1: HW only, 2: both
      wa = 1'($urandom_range(0, 1)); wh = 1'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 15)); ah = AW'($urandom_range(0, 15));
      da = DW'($urandom); dh = DW'($urandom);
      ea = '0; eh = '0;
      avs_first = (mode == 0) || (mode == 2 && lg_model == REQ_HW);
      // apply operations to the reference memory in predicted grant order
      for (int k = 0; k < 2; k++) begin
        if ((k == 0) == avs_first) begin
          if (mode != 1) begin if (wa) ref_mem[aa] = da; else ea = ref_mem[aa]; end
        end else begin
          if (mode != 0) begin if (wh) ref_mem[ah] = dh; else eh = ref_mem[ah]; end
        end
      end
      ela = avs_first ? WC + 2 : 2 * WC + 5;
      elh = (avs_first && mode == 2) ? 2 * WC + 5 : WC + 2;
      lg_model = (mode == 0) ? REQ_AVS : (mode == 1) ? REQ_HW : (avs_first ? REQ_HW : REQ_AVS);
      fork
        begin if (mode != 1) avs_xfer(wa, aa, da, ra, la, sa); end
        begin if (mode != 0) hw_xfer(wh, ah, dh, rh, lh, sh); end
      join
      if (mode != 1) begin
        checks++; if (la !== ela || (!wa && ra !== ea)) begin
          failures++; $display("FAIL rand%0d_avs: lat %0d data %h expected %0d %h", r, la, ra, ela, ea); end
      end
      if (mode != 0) begin
        checks++; if (lh !== elh || (!wh && rh !== eh)) begin
          failures++; $display("FAIL rand%0d_hw: lat %0d data %h expected %0d %h", r, lh, rh, elh, eh); end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [DW-1:0] rd; int lat, st, n, ack_base;
    avs_xfer(1'b0, 10'h155, '0, rd, lat, st);
    hw_xfer(1'b0, 10'h3FF, '0, rd, lat, st);
    checks++; if (bus.avs_readdata !== 16'hA5C3 || bus.hw_rdata !== 16'h00FF) begin
      failures++; $display("FAIL prime_rdata: got %h/%h expected a5c3/00ff", bus.avs_readdata, bus.hw_rdata); end
    tick();
    bus.avs_address = 10'h02A; bus.avs_writedata = 16'hBEEF; bus.avs_write = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.sram_we_n !== 1'b0 && n < BOUND);
    checks++; if (n >= BOUND) begin
      failures++; $display("FAIL mid_reset_reach_access: got timeout after %0d expected we_n low", n); end
    ack_base = ack_count;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== 4'b1110) begin
      failures++; $display("FAIL mid_reset_strobes: got %b expected 1110", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}); end
    checks++; if ({bus.avs_readdata, bus.hw_rdata} !== '0 || bus.avs_waitrequest !== 1'b1) begin
      failures++; $display("FAIL mid_reset_data_wait: got %h/%h waitreq %b expected 0/0 1", bus.avs_readdata, bus.hw_rdata, bus.avs_waitrequest); end
    bus.avs_write = 1'b0;
    tick(); reset_n = 1'b1;
    lg_model = REQ_HW;
    repeat (4) tick();
    checks++; if (ack_count !== ack_base || bus.sram_ce_n !== 1'b1) begin
      failures++; $display("FAIL mid_reset_no_completion: acks %0d ce_n %b expected %0d 1", ack_count, bus.sram_ce_n, ack_base); end
    hw_xfer(1'b1, 10'h02A, 16'h1357, rd, lat, st);
    ref_mem[10'h02A] = 16'h1357;
    checks++; if (lat !== WC + 2) begin
      failures++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, WC + 2); end
    tick();
    checks++; if (acc_we_lo !== WC) begin
      failures++; $display("FAIL post_reset_we_len: got %0d expected %0d", acc_we_lo, WC); end
    avs_xfer(1'b0, 10'h02A, '0, rd, lat, st);
    lg_model = REQ_AVS;
    checks++; if (rd !== ref_mem[10'h02A]) begin
      failures++; $display("FAIL post_reset_readback: got %h expected %h", rd, ref_mem[10'h02A]); end
  endtask

  // WAIT_CYCLES=1 instance: latency 1+1+1+1 = 4 cycles, oe_n low for SETUP+1 cycles.
  task automatic test_wait1();
    int n, oe;
    logic [DW-1:0] d;
    d = DW'($urandom);
    tick();
    bus1.avs_address = 10'h007; bus1.avs_writedata = d; bus1.avs_write = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus1.avs_waitrequest && n < BOUND);
    bus1.avs_write = 1'b0;
    checks++; if (n !== WC1 + 2) begin
      failures++; $display("FAIL w1_write_latency: got %0d expected %0d", n, WC1 + 2); end
    tick();
    bus1.avs_read = 1'b1;
    n = 0; oe = 0;
    do begin tick(); n++; if (!bus1.sram_oe_n) oe++; end while (bus1.avs_waitrequest && n < BOUND);
    bus1.avs_read = 1'b0;
    checks++; if (n !== WC1 + 2 || oe !== WC1 + 1) begin
      failures++; $display("FAIL w1_read_timing: lat %0d oe_lo %0d expected %0d %0d", n, oe, WC1 + 2, WC1 + 1); end
    checks++; if (bus1.avs_readdata !== d) begin
      failures++; $display("FAIL w1_read_data: got %h expected %h", bus1.avs_readdata, d); end
  endtask

  initial begin
    bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    bus.hw_req = 1'b0; bus.hw_we = 1'b0; bus.hw_addr = '0; bus.hw_wdata = '0;
    bus1.avs_address = '0; bus1.avs_read = 1'b0; bus1.avs_write = 1'b0; bus1.avs_writedata = '0;
    bus1.hw_req = 1'b0; bus1.hw_we = 1'b0; bus1.hw_addr = '0; bus1.hw_wdata = '0;
    test_reset();
    test_avs_write_read();
    test_round_robin();
    test_hw_back_to_back();
    test_random();
    test_reset_mid_access();
    test_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Sequences every access to the external asynchronous SRAM and shares it between two requesters. The requesters are the Nios II Avalon-MM slave port and a hardware port driven by board logic (switch-selected address and data). The block converts single-word requests into timed SRAM read/write cycles with fixed wait states. It sits between the Nios II system interconnect and the SRAM pins, alongside the address/data PIOs.

Parameters:
ADDR_W, 10, SRAM word-address width
DATA_W, 16, SRAM data width
WAIT_CYCLES, 2, cycles the strobe (oe_n or we_n) is held low; legal range 1..15

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  Avalon word address
avs_read  in  1  Avalon read request
avs_write  in  1  Avalon write request
avs_writedata  in  DATA_W  Avalon write data
avs_readdata  out  DATA_W  Avalon read data, valid when avs_waitrequest=0 on a read
avs_waitrequest  out  1  Avalon stall
hw_req  in  1  hardware-port request, level, held until hw_ack
hw_we  in  1  1=write, 0=read
hw_addr  in  ADDR_W  hardware-port address
hw_wdata  in  DATA_W  hardware-port write data
hw_rdata  out  DATA_W  hardware-port read data, valid from hw_ack until the next hw read completes
hw_ack  out  1  one-cycle completion pulse
sram_addr  out  ADDR_W  SRAM address
sram_dq_out  out  DATA_W  SRAM write data
sram_dq_oe  out  1  tristate enable for sram_dq_out
sram_dq_in  in  DATA_W  SRAM read data
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - sram_ce_n, sram_oe_n and sram_we_n =1; sram_dq_oe=0.
  - sram_addr, sram_dq_out, avs_readdata and hw_rdata =0; hw_ack=0.
  - last_grant=HW, so AVS wins the first tie.
  - Reset mid-cycle aborts the access immediately; there is no completion pulse and no data update.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - A request is pending when avs_read|avs_write=1 or hw_req=1.
  - One requester pending: grant it.
  - Both pending: grant the one not equal to last_grant; last_grant updates on every grant.
  - On grant, latch address, write data and direction. AVS direction is write if avs_write=1; read and write asserted together is treated as a write.
  - Go to SETUP.
- SETUP (1 cycle):
  - sram_addr is driven from the latch; sram_ce_n=0.
  - Write: sram_dq_oe=1 and sram_dq_out=latched data. Read: sram_oe_n=0.
- ACCESS (WAIT_CYCLES cycles, down-counter):
  - Write: sram_we_n=0 for exactly WAIT_CYCLES cycles.
  - Read: sram_oe_n stays 0, and sram_dq_in is registered on the clock edge that exits ACCESS.
  - The registered read value goes to avs_readdata or hw_rdata according to the grant.
- DONE (1 cycle):
  - sram_we_n=1 while address, data and sram_dq_oe are held (hold time). sram_ce_n=0 and sram_oe_n=1.
  - AVS grant: avs_waitrequest=0 this cycle only.
  - HW grant: hw_ack=1 this cycle only.
  - Next state is IDLE; ce_n and dq_oe go inactive in IDLE.
- avs_waitrequest = (avs_read|avs_write) & ~(state==DONE & grant==AVS). It is 0 when there is no AVS request.
- Latency from request to completion with no contention: 1+1+WAIT_CYCLES+1 cycles (5 at default).
- Back-to-back requests always pass through one IDLE cycle, so the minimum period is WAIT_CYCLES+3.
- An hw_req deasserted after grant does not cancel the access; hw_ack still pulses.
- Address is used modulo 2^ADDR_W; there is no wrap logic and no bounds error.
- The other requester waits with no timeout. Round-robin bounds its wait to one access.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle -> all SRAM strobes=1, sram_dq_oe=0, readdata=0 asynchronously. Release -> state IDLE, no hw_ack.
2. AVS write 0xA5C3 to 0x155, then read 0x155 (SRAM model) -> each transfer has avs_waitrequest high 4 cycles then low 1. sram_we_n is low exactly 2 cycles with sram_addr=0x155 stable from SETUP through DONE. Read returns 0xA5C3.
3. Simultaneous avs_read and hw_req asserted from reset, held for 4 transactions -> grant order AVS, HW, AVS, HW, with hw_ack pulsing on the 2nd and 4th completions.
4. HW back-to-back write 0x00FF to 0x3FF then read 0x3FF -> hw_ack pulses 6 cycles apart, hw_rdata=0x00FF, sram_addr=0x3FF.
5. Reset asserted during ACCESS of a write -> sram_we_n returns to 1 immediately, no completion pulse; the next request after release runs a full cycle.
6. WAIT_CYCLES=1 build: read -> sram_oe_n low for SETUP+1 cycles, total latency 4 cycles, data correct.
